spm_seq_driver: RTL and testbench

Sequencer and result collector for the serial-parallel multiplier (`spm`). It accepts a parallel operand pair over a valid/ready request port, presents the multiplicand in parallel and the multiplier bit-serially, LSB first, to `spm`. It captures the serial product stream from `spm` and returns the full 2·WIDTH-bit product over a valid/ready result port. It sits between the bus-facing register block and the `spm` core and is the write/read end of the `spm` x/y/p interface.

---
 rtl/spm_pkg.sv | 30 +++
 rtl/spm_prod_shreg.sv | 52 +++++
 rtl/spm_seq_driver.sv | 181 ++++++++++++++++++
 tb/tb_spm_seq_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// -----------------------------------------------------------------------------
// spm_pkg
//   Shared types and constants for the serial-parallel multiplier sequencer.
//   - spm_seq_state_t : sequencer FSM states (IDLE, SHIFT, DONE)
//   - SPM_WIDTH_DEF   : default operand width
//   - SPM_P_LAT_DEF   : default spm_y -> spm_p latency in cycles
//   - spm_cnt_w()     : width of the SHIFT-phase cycle counter
// -----------------------------------------------------------------------------
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spm_seq_state_t;

    localparam int SPM_WIDTH_DEF = 32;
    localparam int SPM_P_LAT_DEF = 1;

    // The counter only has to reach 2*width+p_lat-1, never wrap.
    function automatic int spm_cnt_w(input int width, input int p_lat);
        int n;
        n = 2 * width + p_lat;
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/spm_prod_shreg.sv
// -----------------------------------------------------------------------------
// spm_prod_shreg
//   Right-shift capture register. Each enabled cycle the new bit enters at the
//   MSB and everything moves one place toward the LSB, so after WIDTH captures
//   the first bit captured sits at bit 0. Clear has priority over enable.
//
//   Ports:
//     clk  in  1      rising-edge clock
//     rst  in  1      synchronous active-low reset (register -> 0)
//     clr  in  1      synchronous clear
//     en   in  1      shift in din this cycle
//     din  in  1      serial input bit
//     q    out WIDTH  register contents
//
//   WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module spm_prod_shreg
    import spm_pkg::*;
#(
    parameter int WIDTH = 2 * SPM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = {din, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/spm_seq_driver.sv
// -----------------------------------------------------------------------------
// spm_seq_driver
//   Sequencer and result collector for the serial-parallel multiplier (spm).
//   Accepts an operand pair, drives the multiplicand in parallel and the
//   multiplier LSB first on spm_y, collects the serial product from spm_p and
//   returns the 2*WIDTH-bit product on a valid/ready port.
//
//   Parameters:
//     WIDTH  operand width (must match spm)
//     P_LAT  cycles from a bit on spm_y to the matching bit on spm_p (0..3)
//
//   Ports:
//     clk        in  1         rising-edge clock
//     rst        in  1         synchronous active-low reset (shared with spm)
//     req_valid  in  1         operand pair valid
//     req_ready  out 1         idle, able to accept an operand pair
//     req_a      in  WIDTH     multiplicand
//     req_b      in  WIDTH     multiplier
//     spm_x      out WIDTH     parallel multiplicand to spm
//     spm_y      out 1         serial multiplier bit to spm
//     spm_p      in  1         serial product bit from spm
//     res_valid  out 1         product available
//     res_ready  in  1         consumer takes the product
//     res_p      out 2*WIDTH   product
//
//   Build option:
//     SPM_SEQ_SIGNED_EN  defined   -> two's-complement operands; the upper
//                                     WIDTH y cycles carry b[WIDTH-1]
//                        undefined -> unsigned operands; upper y cycles are 0
//     spm must be built with the same signedness.
// -----------------------------------------------------------------------------
module spm_seq_driver
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH_DEF,
    parameter int P_LAT = SPM_P_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    input  logic               spm_p,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_p
);

    localparam int N_SHIFT = 2 * WIDTH + P_LAT;
    localparam int CNT_W   = spm_cnt_w(WIDTH, P_LAT);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N_SHIFT - 1);

    spm_seq_state_t   state_q;
    spm_seq_state_t   state_d;
    logic [CNT_W-1:0] k_q;
    logic [CNT_W-1:0] k_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_sh_q;
    logic [WIDTH-1:0] y_sh_d;
    logic             req_ready_q;
    logic             req_ready_d;
    logic             res_valid_q;
    logic             res_valid_d;

    logic             y_ext;
    logic             cap_ok;
    logic             prod_clr;
    logic             prod_en;

    // Bit fed into the top of the y shifter once the real multiplier bits
    // are used up. These WIDTH extra cycles also drain spm's carry-save
    // state, so no separate spm reset is needed between operations.
`ifdef SPM_SEQ_SIGNED_EN
    assign y_ext = y_sh_q[WIDTH-1];
`else
    assign y_ext = 1'b0;
`endif

    // The first P_LAT SHIFT cycles only fill spm's pipeline; product bit 0
    // appears on spm_p at k == P_LAT.
    if (P_LAT == 0) begin : g_cap_nolat
        assign cap_ok = 1'b1;
    end else begin : g_cap_lat
        assign cap_ok = (k_q >= CNT_W'(P_LAT));
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_sh_d      = y_sh_q;
        req_ready_d = req_ready_q;
        res_valid_d = res_valid_q;
        prod_clr    = 1'b0;
        prod_en     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                // req_ready_q is the registered handshake, so the first
                // cycle after reset release never accepts.
                if (req_valid && req_ready_q) begin
                    state_d     = SHIFT;
                    x_d         = req_a;
                    y_sh_d      = req_b;
                    k_d         = '0;
                    prod_clr    = 1'b1;
                    req_ready_d = 1'b0;
                end
            end

            SHIFT: begin
                // y_sh_q[0] is the bit on spm_y this cycle (b[k]).
                y_sh_d  = {y_ext, y_sh_q[WIDTH-1:1]};
                k_d     = k_q + 1'b1;
                prod_en = cap_ok;
                if (k_q == K_LAST) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    y_sh_d      = '0;
                    k_d         = '0;
                end
            end

            DONE: begin
                // req_ready only returns the cycle after the result is taken,
                // so a result and a new request never share a cycle.
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            x_q         <= '0;
            y_sh_q      <= '0;
            req_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_sh_q      <= y_sh_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    spm_prod_shreg #(
        .WIDTH (2 * WIDTH)
    ) u_prod (
        .clk (clk),
        .rst (rst),
        .clr (prod_clr),
        .en  (prod_en),
        .din (spm_p),
        .q   (res_p)
    );

    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign spm_x     = x_q;
    assign spm_y     = y_sh_q[0];

endmodule

// File: tb/tb_spm_seq_driver.sv
// -----------------------------------------------------------------------------
// tb_spm_seq_driver
//   Three sequencer instances (WIDTH=8; P_LAT = 1, 0, 3), each paired with a
//   behavioural serial multiplier that produces product bit k from the
//   multiplicand on spm_x and the multiplier bits seen so far on spm_y,
//   delayed by P_LAT cycles. Instance 0 runs the directed tests, instances
//   1 and 2 the random sweeps. Respects SPM_SEQ_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_spm_seq_driver;
    import spm_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;

    logic           req_valid [3];
    logic           req_ready [3];
    logic [W-1:0]   req_a     [3];
    logic [W-1:0]   req_b     [3];
    logic [W-1:0]   spm_x     [3];
    logic           spm_y     [3];
    logic           res_valid [3];
    logic           res_ready [3];
    logic [2*W-1:0] res_p     [3];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        logic           p_bit;
        logic           m_act;
        logic [4:0]     mk;
        logic [2*W-1:0] my;
        logic [3:0]     dl;
        logic           pnow;
        logic [2*W-1:0] xe;
        logic [2*W-1:0] yn;
        logic [2*W-1:0] pr;

        spm_seq_driver #(
            .WIDTH (W),
            .P_LAT (LAT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_a     (req_a[g]),
            .req_b     (req_b[g]),
            .spm_x     (spm_x[g]),
            .spm_y     (spm_y[g]),
            .spm_p     (p_bit),
            .res_valid (res_valid[g]),
            .res_ready (res_ready[g]),
            .res_p     (res_p[g])
        );

        // Serial multiplier model: bit k of x*y only depends on y[k:0].
        always_comb begin
`ifdef SPM_SEQ_SIGNED_EN
            xe = {{W{spm_x[g][W-1]}}, spm_x[g]};
`else
            xe = {{W{1'b0}}, spm_x[g]};
`endif
            yn   = my | ({{(2*W-1){1'b0}}, spm_y[g]} << mk);
            pr   = xe * yn;
            pnow = (m_act && (int'(mk) < 2 * W)) ? pr[mk[3:0]] : 1'b0;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                m_act <= 1'b0;
                mk    <= '0;
                my    <= '0;
                dl    <= '0;
            end else begin
                dl <= {dl[2:0], pnow};
                if (req_valid[g] && req_ready[g]) begin
                    m_act <= 1'b1;
                    mk    <= '0;
                    my    <= '0;
                end else if (m_act) begin
                    my <= yn;
                    mk <= mk + 5'd1;
                    if (int'(mk) == 2 * W + LAT - 1) begin
                        m_act <= 1'b0;
                    end
                end
            end
        end

        if (LAT == 0) begin : g_p0
            assign p_bit = pnow;
        end else begin : g_pd
            assign p_bit = dl[LAT-1];
        end
    end

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_u;
        logic [2*W-1:0] exp_s;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ae;
        logic [2*W-1:0] be;
`ifdef SPM_SEQ_SIGNED_EN
        ae = {{W{a[W-1]}}, a};
        be = {{W{b[W-1]}}, b};
`else
        ae = {{W{1'b0}}, a};
        be = {{W{1'b0}}, b};
`endif
        return ae * be;
    endfunction

    // One operation on instance idx. While the operation runs, req_valid
    // stays high with different operands; they must be ignored.
    task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W-1:0] p, output int lat);
        int guard;
        guard = 0;
        while (req_ready[idx] !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_valid[idx] = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        req_a[idx] = ~a;
        req_b[idx] = b ^ 8'h5A;
        while (res_valid[idx] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        req_valid[idx] = 1'b0;
        p = res_p[idx];
    endtask

    initial begin
        logic [2*W-1:0] p;
        logic [2*W-1:0] exp;
        int             lat;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;

        vecs[0] = '{a: 8'd3,   b: 8'd5,   exp_u: 16'h000F, exp_s: 16'h000F};
        vecs[1] = '{a: 8'hFE,  b: 8'd3,   exp_u: 16'h02FA, exp_s: 16'hFFFA};
        vecs[2] = '{a: 8'h80,  b: 8'h80,  exp_u: 16'h4000, exp_s: 16'h4000};
        vecs[3] = '{a: 8'hFF,  b: 8'hFF,  exp_u: 16'hFE01, exp_s: 16'h0001};
        vecs[4] = '{a: 8'h00,  b: 8'h55,  exp_u: 16'h0000, exp_s: 16'h0000};
        vecs[5] = '{a: 8'h01,  b: 8'hFF,  exp_u: 16'h00FF, exp_s: 16'hFFFF};
        vecs[6] = '{a: 8'h7F,  b: 8'h7F,  exp_u: 16'h3F01, exp_s: 16'h3F01};
        vecs[7] = '{a: 8'h12,  b: 8'h34,  exp_u: 16'h03A8, exp_s: 16'h03A8};

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_a[i]     = '0;
            req_b[i]     = '0;
            res_ready[i] = 1'b1;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready[0]), 64'd0);
        check("rst_res_valid", 64'(res_valid[0]), 64'd0);
        check("rst_res_p",     64'(res_p[0]),     64'd0);
        check("rst_spm_x",     64'(spm_x[0]),     64'd0);
        check("rst_spm_y",     64'(spm_y[0]),     64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", 64'(req_ready[0]), 64'd1);

        // Directed table on the P_LAT=1 instance
        for (int i = 0; i < 8; i++) begin
`ifdef SPM_SEQ_SIGNED_EN
            exp = vecs[i].exp_s;
`else
            exp = vecs[i].exp_u;
`endif
            run_op(0, vecs[i].a, vecs[i].b, p, lat);
            check($sformatf("vec%0d_res_p", i), 64'(p), 64'(exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd18);
            check($sformatf("vec%0d_spm_x", i), 64'(spm_x[0]), 64'(vecs[i].a));
        end

        // Backpressure, then a second operation to confirm no residue
        @(posedge clk); #1;
        res_ready[0] = 1'b0;
        run_op(0, 8'hFF, 8'hFF, p, lat);
`ifdef SPM_SEQ_SIGNED_EN
        exp = 16'h0001;
`else
        exp = 16'hFE01;
`endif
        check("bp_first_res_p", 64'(p), 64'(exp));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_valid_c%0d", c), 64'(res_valid[0]), 64'd1);
            check($sformatf("bp_hold_ready_c%0d", c), 64'(req_ready[0]), 64'd0);
            check($sformatf("bp_hold_res_p_c%0d", c), 64'(res_p[0]), 64'(exp));
        end
        res_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_taken_valid", 64'(res_valid[0]), 64'd0);
        check("bp_taken_ready", 64'(req_ready[0]), 64'd1);
        run_op(0, 8'd7, 8'd9, p, lat);
        check("b2b_res_p",    64'(p),   64'h003F);
        check("b2b_latency",  64'(lat), 64'd18);

        // Reset at SHIFT k=5
        @(posedge clk); #1;
        req_a[0]     = 8'hAB;
        req_b[0]     = 8'hCD;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_req_ready", 64'(req_ready[0]), 64'd0);
        check("mid_rst_res_valid", 64'(res_valid[0]), 64'd0);
        check("mid_rst_res_p",     64'(res_p[0]),     64'd0);
        check("mid_rst_spm_x",     64'(spm_x[0]),     64'd0);
        check("mid_rst_spm_y",     64'(spm_y[0]),     64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_req_ready", 64'(req_ready[0]), 64'd1);
        check("mid_rel_res_valid", 64'(res_valid[0]), 64'd0);
        run_op(0, 8'd2, 8'd2, p, lat);
        check("post_rst_res_p",   64'(p),   64'h0004);
        check("post_rst_latency", 64'(lat), 64'd18);

        // Random sweeps at P_LAT=0 (instance 1) and P_LAT=3 (instance 2)
        for (int inst = 1; inst < 3; inst++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                run_op(inst, ra, rb, p, lat);
                check($sformatf("sweep%0d_%0d_res_p(%0h*%0h)", inst, n, ra, rb),
                      64'(p), 64'(ref_mul(ra, rb)));
                check($sformatf("sweep%0d_%0d_latency", inst, n),
                      64'(lat), 64'(2 * W + ((inst == 1) ? 0 : 3) + 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
